// File: rtl/nios_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
// Imported by the channel slice and the Avalon-MM top.
package nios_multi_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_SNAPSHOT = 3'd4;

    localparam int ST_TO  = 0;
    localparam int ST_RUN = 1;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;
    localparam int CTL_PWM   = 4;

    typedef struct packed {
        logic pwm;
        logic cont;
        logic ito;
    } ctl_t;

    function automatic ctl_t ctl_from_word(input logic [31:0] w);
        ctl_t c;
        c.ito  = w[CTL_ITO];
        c.cont = w[CTL_CONT];
        c.pwm  = w[CTL_PWM];
        return c;
    endfunction

endpackage

// File: rtl/nios_multi_timer_ch.sv
// One timer channel: down-counter with reload, sticky timeout, snapshot
// capture and a registered PWM comparator.
module nios_multi_timer_ch
    import nios_multi_timer_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int RST_PERIOD = 9999
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             wr_status,
    input  logic             wr_control,
    input  logic             wr_period,
    input  logic             wr_compare,
    input  logic             wr_snapshot,
    input  logic [31:0]      wdata,
    output logic             to,
    output logic             run,
    output logic             ctl_ito,
    output logic             ctl_cont,
    output logic             ctl_pwm,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] compare,
    output logic [CNT_W-1:0] snapshot,
    output logic             pwm
);

    localparam logic [CNT_W-1:0] RST_P = CNT_W'(RST_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    ctl_t             ctl_q, ctl_d;
    logic             to_q, to_d;
    logic             run_q, run_d;
    logic             pwm_q, pwm_d;
    logic [CNT_W-1:0] wval;

    assign wval = wdata[CNT_W-1:0];

    always_comb begin
        cnt_d  = cnt_q;
        per_d  = per_q;
        cmp_d  = cmp_q;
        snap_d = snap_q;
        ctl_d  = ctl_q;
        to_d   = to_q;
        run_d  = run_q;

        // Clear first so a timeout in the same cycle re-sets TO.
        if (wr_status) begin
            to_d = 1'b0;
        end

        if (tick && run_q) begin
            if (cnt_q == '0) begin
                cnt_d = per_q;
                to_d  = 1'b1;
                if (!ctl_q.cont) begin
                    run_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        if (wr_control) begin
            ctl_d = ctl_from_word(wdata);
            if (wdata[CTL_START]) begin
                run_d = 1'b1;
            end else if (wdata[CTL_STOP]) begin
                run_d = 1'b0;
            end
        end

        if (wr_period) begin
            per_d = wval;
            cnt_d = wval;
            run_d = 1'b0;
        end

        if (wr_compare) begin
            cmp_d = wval;
        end

        if (wr_snapshot) begin
            snap_d = cnt_q;
        end

        pwm_d = run_q & ctl_q.pwm & (cnt_q < cmp_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= RST_P;
            per_q  <= RST_P;
            cmp_q  <= '0;
            snap_q <= '0;
            ctl_q  <= '0;
            to_q   <= 1'b0;
            run_q  <= 1'b0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            cmp_q  <= cmp_d;
            snap_q <= snap_d;
            ctl_q  <= ctl_d;
            to_q   <= to_d;
            run_q  <= run_d;
            pwm_q  <= pwm_d;
        end
    end

    assign to       = to_q;
    assign run      = run_q;
    assign ctl_ito  = ctl_q.ito;
    assign ctl_cont = ctl_q.cont;
    assign ctl_pwm  = ctl_q.pwm;
    assign period   = per_q;
    assign compare  = cmp_q;
    assign snapshot = snap_q;
    assign pwm      = pwm_q;

endmodule

// File: rtl/nios_multi_timer.sv
// Avalon-MM multi-channel timer: shared prescaler, register decode,
// registered read mux and interrupt OR over the channel slices.
module nios_multi_timer
    import nios_multi_timer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int PRESCALE   = 1,
    parameter int RST_PERIOD = 9999
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [$clog2(NUM_CH)+2:0]   address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic                        irq,
    output logic [NUM_CH-1:0]           pwm_out
);

    localparam int AW = $clog2(NUM_CH) + 3;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    // Prescaler sits at 0 forever when PRESCALE is 1, giving tick every clk.
    assign tick = (pre_q == PW'(PRESCALE - 1));

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    logic [AW-1:0] ch_sel;
    logic [2:0]    reg_sel;
    logic          wr_en;

    assign ch_sel  = address >> 3;
    assign reg_sel = address[2:0];
    assign wr_en   = chipselect & ~write_n;

    logic [NUM_CH-1:0] hit;
    logic [NUM_CH-1:0] w_st, w_ctl, w_per, w_cmp, w_snap;
    logic [NUM_CH-1:0] to, run, ito, cont, pwmen, pwm;
    logic [CNT_W-1:0]  per  [NUM_CH];
    logic [CNT_W-1:0]  cmp  [NUM_CH];
    logic [CNT_W-1:0]  snap [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i]    = (ch_sel == AW'(i));
            w_st[i]   = wr_en & hit[i] & (reg_sel == REG_STATUS);
            w_ctl[i]  = wr_en & hit[i] & (reg_sel == REG_CONTROL);
            w_per[i]  = wr_en & hit[i] & (reg_sel == REG_PERIOD);
            w_cmp[i]  = wr_en & hit[i] & (reg_sel == REG_COMPARE);
            w_snap[i] = wr_en & hit[i] & (reg_sel == REG_SNAPSHOT);
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        nios_multi_timer_ch #(
            .CNT_W      (CNT_W),
            .RST_PERIOD (RST_PERIOD)
        ) u_ch (
            .clk         (clk),
            .reset_n     (reset_n),
            .tick        (tick),
            .wr_status   (w_st[g]),
            .wr_control  (w_ctl[g]),
            .wr_period   (w_per[g]),
            .wr_compare  (w_cmp[g]),
            .wr_snapshot (w_snap[g]),
            .wdata       (writedata),
            .to          (to[g]),
            .run         (run[g]),
            .ctl_ito     (ito[g]),
            .ctl_cont    (cont[g]),
            .ctl_pwm     (pwmen[g]),
            .period      (per[g]),
            .compare     (cmp[g]),
            .snapshot    (snap[g]),
            .pwm         (pwm[g])
        );
    end

    logic [31:0] rd_q, rd_d;

    // Unmatched channels and offsets 5-7 fall through to zero.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i]) begin
                case (reg_sel)
                    REG_STATUS: begin
                        rd_d[ST_TO]  = to[i];
                        rd_d[ST_RUN] = run[i];
                    end
                    REG_CONTROL: begin
                        rd_d[CTL_ITO]  = ito[i];
                        rd_d[CTL_CONT] = cont[i];
                        rd_d[CTL_PWM]  = pwmen[i];
                    end
                    REG_PERIOD:   rd_d = 32'(per[i]);
                    REG_COMPARE:  rd_d = 32'(cmp[i]);
                    REG_SNAPSHOT: rd_d = 32'(snap[i]);
                    default:      rd_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q <= '0;
            rd_q  <= '0;
        end else begin
            pre_q <= pre_d;
            rd_q  <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign irq      = |(to & ito);
    assign pwm_out  = pwm;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Directed bench for nios_multi_timer: register table plus timing sequences
// on a PRESCALE=1 instance and a PRESCALE=4, 16-bit instance sharing one bus.
module tb_nios_multi_timer;
    import nios_multi_timer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd1, rd4;
    logic        irq1, irq4;
    logic [1:0]  pwm1, pwm4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    nios_multi_timer #(
        .NUM_CH(2), .CNT_W(32), .PRESCALE(1), .RST_PERIOD(9999)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(rd1), .irq(irq1), .pwm_out(pwm1)
    );

    nios_multi_timer #(
        .NUM_CH(2), .CNT_W(16), .PRESCALE(4), .RST_PERIOD(9999)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(rd4), .irq(irq4), .pwm_out(pwm4)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp1;
        logic [31:0] exp4;
    } vec_t;

    vec_t tv [24];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] A(input int ch, input int r);
        return 4'((ch << 3) | r);
    endfunction

    task automatic cyc(input logic c, input logic w, input logic [3:0] a,
                       input logic [31:0] d);
        address    = a;
        chipselect = c;
        write_n    = w;
        writedata  = d;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        cyc(1'b1, 1'b1, a, 32'h0);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b1, 4'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int cnt1;
        int n;

        tv[0]  = '{1'b0, A(0, REG_STATUS),   32'h0, 32'd0, 32'd0};
        tv[1]  = '{1'b0, A(0, REG_CONTROL),  32'h0, 32'd0, 32'd0};
        tv[2]  = '{1'b0, A(0, REG_PERIOD),   32'h0, 32'd9999, 32'd9999};
        tv[3]  = '{1'b0, A(0, REG_COMPARE),  32'h0, 32'd0, 32'd0};
        tv[4]  = '{1'b0, A(0, REG_SNAPSHOT), 32'h0, 32'd0, 32'd0};
        tv[5]  = '{1'b0, A(1, REG_PERIOD),   32'h0, 32'd9999, 32'd9999};
        tv[6]  = '{1'b1, A(0, REG_CONTROL),  32'h1F, 32'd0, 32'd0};
        tv[7]  = '{1'b0, A(0, REG_CONTROL),  32'h0, 32'h13, 32'h13};
        tv[8]  = '{1'b0, A(0, REG_STATUS),   32'h0, 32'h2, 32'h2};
        tv[9]  = '{1'b1, A(0, REG_CONTROL),  32'h08, 32'd0, 32'd0};
        tv[10] = '{1'b0, A(0, REG_STATUS),   32'h0, 32'h0, 32'h0};
        tv[11] = '{1'b0, A(0, REG_CONTROL),  32'h0, 32'h0, 32'h0};
        tv[12] = '{1'b1, A(0, REG_COMPARE),  32'hABCD1234, 32'd0, 32'd0};
        tv[13] = '{1'b0, A(0, REG_COMPARE),  32'h0, 32'hABCD1234, 32'h1234};
        tv[14] = '{1'b1, A(0, 5),            32'hFFFF, 32'd0, 32'd0};
        tv[15] = '{1'b0, A(0, 5),            32'h0, 32'h0, 32'h0};
        tv[16] = '{1'b0, A(1, 7),            32'h0, 32'h0, 32'h0};
        tv[17] = '{1'b1, A(1, REG_PERIOD),   32'h55, 32'd0, 32'd0};
        tv[18] = '{1'b0, A(1, REG_PERIOD),   32'h0, 32'h55, 32'h55};
        tv[19] = '{1'b0, A(0, REG_PERIOD),   32'h0, 32'd9999, 32'd9999};
        tv[20] = '{1'b1, A(1, REG_SNAPSHOT), 32'h0, 32'd0, 32'd0};
        tv[21] = '{1'b0, A(1, REG_SNAPSHOT), 32'h0, 32'h55, 32'h55};
        tv[22] = '{1'b1, A(0, REG_COMPARE),  32'h0, 32'd0, 32'd0};
        tv[23] = '{1'b0, A(1, REG_STATUS),   32'h0, 32'h0, 32'h0};

        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", rd1, 32'h0);
        check("rst_irq", irq1, 1'b0);
        check("rst_pwm", pwm1, 2'b00);
        check("rst_readdata4", rd4, 32'h0);
        reset_n = 1'b1;

        foreach (tv[i]) begin
            if (tv[i].wr) begin
                wr(tv[i].addr, tv[i].data);
            end else begin
                rd(tv[i].addr);
                check($sformatf("reg_vec%0d", i), rd1, tv[i].exp1);
                check($sformatf("reg_vec%0d_p4", i), rd4, tv[i].exp4);
            end
        end

        // Continuous ch0, PERIOD=5: TO every 6 clks; clear at k=7.
        wr(A(0, REG_PERIOD), 32'd5);
        wr(A(0, REG_CONTROL), 32'h7);
        for (int k = 1; k <= 12; k++) begin
            if (k == 7) wr(A(0, REG_STATUS), 32'h0);
            else idle();
            check($sformatf("cont_irq_k%0d", k), irq1, (k == 6 || k == 12));
        end

        // Clear and timeout in the same clk: set wins.
        wr(A(0, REG_STATUS), 32'h0);
        repeat (4) idle();
        check("pre_setwin_irq", irq1, 1'b0);
        wr(A(0, REG_STATUS), 32'h0);
        check("setwin_irq", irq1, 1'b1);
        rd(A(0, REG_STATUS));
        check("setwin_status", rd1, 32'h3);
        wr(A(0, REG_STATUS), 32'h0);
        check("clear_irq", irq1, 1'b0);
        rd(A(0, REG_STATUS));
        check("clear_status", rd1, 32'h2);
        wr(A(0, REG_CONTROL), 32'h8);
        wr(A(0, REG_STATUS), 32'h0);

        // One-shot on ch1, PERIOD=3.
        wr(A(1, REG_PERIOD), 32'd3);
        wr(A(1, REG_CONTROL), 32'h5);
        repeat (3) idle();
        check("oneshot_pre_irq", irq1, 1'b0);
        idle();
        check("oneshot_irq", irq1, 1'b1);
        repeat (4) idle();
        rd(A(1, REG_STATUS));
        check("oneshot_status", rd1, 32'h1);
        wr(A(1, REG_SNAPSHOT), 32'h0);
        rd(A(1, REG_SNAPSHOT));
        check("oneshot_snap", rd1, 32'd3);
        wr(A(1, REG_STATUS), 32'h0);
        repeat (10) idle();
        check("oneshot_no_retrig", irq1, 1'b0);
        rd(A(1, REG_STATUS));
        check("oneshot_status_end", rd1, 32'h0);

        // PRESCALE=4 instance, PERIOD=2: TO period 12 clks.
        wr(A(1, REG_CONTROL), 32'h0);
        wr(A(1, REG_STATUS), 32'h0);
        wr(A(0, REG_PERIOD), 32'd2);
        wr(A(0, REG_CONTROL), 32'h7);
        for (int i = 0; i < 40 && !irq4; i++) idle();
        check("p4_first_to", irq4, 1'b1);
        wr(A(0, REG_STATUS), 32'h0);
        n = 1;
        while (!irq4 && n < 40) begin
            idle();
            n++;
        end
        check("p4_period", n, 32'd12);
        wr(A(0, REG_CONTROL), 32'h8);
        wr(A(0, REG_STATUS), 32'h0);

        // PWM: PERIOD=9, COMPARE=3 -> 3 of every 10 ticks.
        wr(A(0, REG_PERIOD), 32'd9);
        wr(A(0, REG_COMPARE), 32'd3);
        wr(A(0, REG_CONTROL), 32'h16);
        repeat (3) idle();
        cnt = 0;
        cnt1 = 0;
        for (int i = 0; i < 30; i++) begin
            idle();
            cnt += int'(pwm1[0]);
            cnt1 += int'(pwm1[1]);
        end
        check("pwm_duty", cnt, 32'd9);
        check("pwm_ch1_idle", cnt1, 32'd0);
        wr(A(0, REG_COMPARE), 32'd20);
        idle();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            cnt += int'(pwm1[0]);
        end
        check("pwm_cmp_gt_per", cnt, 32'd20);
        wr(A(0, REG_COMPARE), 32'd0);
        idle();
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            cnt += int'(pwm1[0]);
        end
        check("pwm_cmp_zero", cnt, 32'd0);

        // Reset pulse mid-count.
        wr(A(0, REG_COMPARE), 32'd20);
        wr(A(0, REG_CONTROL), 32'h17);
        repeat (12) idle();
        check("pre_rst_irq", irq1, 1'b1);
        check("pre_rst_pwm", pwm1[0], 1'b1);
        rd(A(0, REG_PERIOD));
        check("pre_rst_rd", rd1, 32'd9);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_rd", rd1, 32'h0);
        check("async_rst_irq", irq1, 1'b0);
        check("async_rst_pwm", pwm1, 2'b00);
        check("async_rst_rd4", rd4, 32'h0);
        check("async_rst_pwm4", pwm4, 2'b00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(A(0, REG_PERIOD));
        check("post_rst_period", rd1, 32'd9999);
        rd(A(0, REG_COMPARE));
        check("post_rst_compare", rd1, 32'd0);
        repeat (20) idle();
        check("post_rst_irq", irq1, 1'b0);
        check("post_rst_pwm", pwm1, 2'b00);
        rd(A(0, REG_STATUS));
        check("post_rst_status", rd1, 32'h0);
        check("post_rst_status4", rd4, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_multi_timer.md
NIOS_MULTI_TIMER -- requirements
Module: nios_multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/period/compare width (8..32).
REQ-003 SHALL have parameter PRESCALE, default 1, shared tick divider (1..65536; 1 = tick every clk).
REQ-004 SHALL have parameter RST_PERIOD, default 9999, reset value of every period register.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port address  input  $clog2(NUM_CH)+3  {channel, reg[2:0]}.
REQ-008 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-009 SHALL have port write_n  input  1  active-low write strobe.
REQ-010 SHALL have port writedata  input  32  write data; bits above CNT_W ignored.
REQ-011 SHALL have port readdata  output  32  registered read data, zero-extended.
REQ-012 SHALL have port irq  output  1  OR of all channel interrupts.
REQ-013 SHALL have port pwm_out  output  NUM_CH  per-channel PWM output.

Function
REQ-014 SHALL decode per-channel reg: 0 STATUS (b0 TO, b1 RUN), 1 CONTROL (b0 ITO, b1 CONT, b2 START, b3 STOP, b4 PWM), 2 PERIOD, 3 COMPARE, 4 SNAPSHOT; regs 5-7 and channels >= NUM_CH read 0, writes ignored.
REQ-015 SHALL write only when chipselect=1 and write_n=0; CONTROL stores b0,b1,b4; START/STOP are strobes, read as 0.
REQ-016 SHALL present readdata one clk after address (no wait states, reads side-effect free).
REQ-017 SHALL generate shared tick: prescale counter 0..PRESCALE-1, tick asserted one clk when count = PRESCALE-1; PRESCALE=1 -> tick every clk.
REQ-018 SHALL decrement a running channel counter by 1 on each tick while nonzero.
REQ-019 SHALL on tick with RUN=1 and counter=0: reload PERIOD, set TO; if CONT=0 clear RUN (one-shot).
REQ-020 SHALL with PERIOD=0 and CONT=1 set TO on every tick.
REQ-021 SHALL on PERIOD write: update PERIOD, next clk load counter with new PERIOD and clear RUN.
REQ-022 SHALL on START strobe set RUN next clk; START and STOP in same write -> START wins.
REQ-023 SHALL on STATUS write (any data) clear TO; timeout in same clk -> TO set (set wins).
REQ-024 SHALL on SNAPSHOT write capture live counter into snapshot next clk; SNAPSHOT read returns captured value.
REQ-025 SHALL drive irq = OR over channels of (TO & ITO), combinational from registers.
REQ-026 SHALL drive pwm_out[ch] registered: 1 when RUN & PWM & counter < COMPARE, else 0; COMPARE=0 -> constant 0, COMPARE > PERIOD -> constant 1 while running.
REQ-027 SHALL keep channels fully independent; simultaneous timeouts on several channels all set their TO.

Reset
REQ-028 SHALL on reset_n=0 asynchronously set: counter and PERIOD = RST_PERIOD, COMPARE=0, snapshot=0, CONTROL=0, TO=0, RUN=0, prescale count=0, readdata=0, pwm_out=0, irq=0.
REQ-029 SHALL resume from reset-values on first clk after reset_n deasserts; reset mid-count discards all state.

Structure
REQ-030 SHALL place register offsets (0-4) and CONTROL/STATUS bit positions in shared package nios_multi_timer_pkg.
REQ-031 SHALL implement one channel (counter, PERIOD, COMPARE, snapshot, CONTROL, TO/RUN, pwm) as sub-module nios_multi_timer_ch, instantiated NUM_CH times; top holds prescaler, decode, read mux, irq OR.

Verification
REQ-032 SHALL verify: NUM_CH=2, PRESCALE=1, ch0 PERIOD=5, CONTROL=0x7 -> TO and irq rise 6 clks after START, repeat every 6 clks.
REQ-033 SHALL verify: ch1 PERIOD=3, CONT=0, START -> single TO, RUN=0 afterwards, counter holds 3.
REQ-034 SHALL verify: PRESCALE=4, PERIOD=2, continuous -> TO period 12 clks.
REQ-035 SHALL verify: STATUS write in same clk as timeout -> TO reads 1; later STATUS write -> TO=0, irq=0.
REQ-036 SHALL verify: PERIOD=9, COMPARE=3, PWM=1, continuous -> pwm_out high 3 of every 10 ticks.
REQ-037 SHALL verify: reset_n pulsed mid-count -> all outputs 0, PERIOD reads 9999, no TO until restarted.
